ntt_seq_ctrl: RTL and testbench
===============================

Name: ntt_seq_ctrl

Overview:
- Sequencing controller for the polynomial arithmetic unit.
- Accepts an operation request (NTT, INVNTT, MULT, ADDSUB) and drives the `mode`, `stage` and `cycle_cnt` buses consumed by the downstream address generator.
- Also drives the memory read/write enables, including the pipeline-drain window that protects read-after-write ordering between NTT stages.
- Sits directly between the top-level command interface and the address generator / butterfly datapath.

Parameters:
- NUM_STAGES, 7, number of butterfly layers per NTT/INVNTT (stage runs 0..NUM_STAGES-1).
- NTT_LEN, 32, read cycles per NTT/INVNTT stage.
- NTT_LAT, 6, read-to-write pipeline latency for NTT/INVNTT.
- MULT_LEN, 128, read cycles for MULT (4 cycles per word, 32 words).
- MULT_LAT, 12, write offset for MULT.
- ADDSUB_LEN, 64, read cycles for ADDSUB (2 cycles per word).
- ADDSUB_LAT, 4, write offset for ADDSUB.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  operation request, sampled only in IDLE.
- op  in  2  requested operation: 0=NTT, 1=INVNTT, 2=MULT, 3=ADDSUB.
- mode  out  2  latched operation, to the address generator.
- stage  out  3  current layer index.
- cycle_cnt  out  8  cycle counter within the current stage/operation.
- rd_en  out  1  coefficient memory read enable.
- wr_en  out  1  coefficient memory write enable.
- busy  out  1  high while an operation is in progress.
- stage_done  out  1  one-cycle pulse on the last cycle of each stage.
- done  out  1  one-cycle pulse after the operation completes.

Behaviour:
- Reset: rst is asynchronous and active-high; clock is clk. On reset, state=IDLE and all outputs are 0 (mode=0, stage=0, cycle_cnt=0, rd_en=wr_en=busy=stage_done=done=0).
- Per-operation constants:
  - LEN/LAT = NTT_LEN/NTT_LAT for NTT and INVNTT.
  - LEN/LAT = MULT_LEN/MULT_LAT for MULT.
  - LEN/LAT = ADDSUB_LEN/ADDSUB_LAT for ADDSUB.
  - LAST = LEN+LAT-1.
  - Stage count is NUM_STAGES for NTT/INVNTT and 1 for MULT/ADDSUB.
- States: IDLE, RUN, DONE.
- IDLE:
  - cycle_cnt and stage are held at 0.
  - On start=1: latch mode<=op, stage<=0, cycle_cnt<=0, go to RUN.
  - busy rises in the same edge.
- RUN:
  - busy=1.
  - cycle_cnt increments by 1 every cycle from 0 to LAST. The counter keeps counting through the drain window, because the downstream block derives write addresses from cycle_cnt (MULT/ADDSUB) or from a free-running delay line (NTT/INVNTT).
  - rd_en = (cycle_cnt < LEN).
  - wr_en = (cycle_cnt >= LAT) && (cycle_cnt <= LAST).
  - Both enables are combinational from the registered state/cycle_cnt/mode.
  - stage_done = (cycle_cnt == LAST).
  - At cycle_cnt==LAST with stage < stage count-1: stage<=stage+1, cycle_cnt<=0, remain in RUN. The next stage issues no reads until every write of the previous stage has been issued.
  - At cycle_cnt==LAST on the final stage: go to DONE, cycle_cnt<=0.
- DONE:
  - Lasts exactly one cycle: done=1, busy=0, rd_en=wr_en=0, stage held at its final value.
  - Next state is IDLE, with stage<=0.
  - start asserted in DONE is ignored.
- mode holds the last latched op through DONE and IDLE until the next start.
- start and op are ignored while in RUN or DONE; op changes mid-operation have no effect.
- Cycles from start edge to done (inclusive of DONE):
  - NTT/INVNTT: 7*38+1 = 267.
  - MULT: 140+1 = 141.
  - ADDSUB: 68+1 = 69.
- Width rules:
  - cycle_cnt is 8 bits; LAST never exceeds 139, so there is no wrap.
  - stage is 3 bits; maximum value is 6.
- Reset mid-operation: immediate return to IDLE with all outputs 0. No done pulse. The next start begins from stage 0.
- Back-to-back operations: the earliest new start is sampled in the IDLE cycle following DONE.

Test Plan:
- Reset, then start with op=0 → mode=0 from the next cycle.
  - stage steps 0..6.
  - cycle_cnt 0..37 per stage.
  - rd_en high at cnt 0..31; wr_en high at cnt 6..37.
  - Seven stage_done pulses; done pulse at cycle 267 after start; busy low at done.
- op=1 (INVNTT) → identical timing to NTT with mode=1; stage still counts 0..6.
- op=2 (MULT) → stage stays 0.
  - rd_en high at cnt 0..127; wr_en high at cnt 12..139.
  - Single stage_done at cnt=139; done 141 cycles after start.
- op=3 (ADDSUB) → rd_en at cnt 0..63; wr_en at cnt 4..67; done 69 cycles after start.
- During an NTT at stage 3, cnt 10:
  - Toggle op and pulse start → no effect on mode/stage/cnt.
  - Then assert rst asynchronously mid-cycle → outputs 0 immediately, no done.
  - A new start with op=2 runs a clean MULT.
- Hold start high continuously with op=3 → operations repeat with one IDLE cycle between DONE and the next RUN, giving a 70-cycle period with done every 70 cycles.

Source files
------------

// File: rtl/ntt_seq_ctrl.sv
// ntt_seq_ctrl: sequences NTT/INVNTT/MULT/ADDSUB stages, counters and memory enables
module ntt_seq_ctrl #(
    parameter int NUM_STAGES = 7,
    parameter int NTT_LEN    = 32,
    parameter int NTT_LAT    = 6,
    parameter int MULT_LEN   = 128,
    parameter int MULT_LAT   = 12,
    parameter int ADDSUB_LEN = 64,
    parameter int ADDSUB_LAT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] op,
    output logic [1:0] mode,
    output logic [2:0] stage,
    output logic [7:0] cycle_cnt,
    output logic       rd_en,
    output logic       wr_en,
    output logic       busy,
    output logic       stage_done,
    output logic       done
);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    state_t     state_q;
    logic [1:0] mode_q;
    logic [2:0] stage_q;
    logic [7:0] cnt_q;
    logic [7:0] len, lat, last;
    logic [2:0] last_stg;
    logic       run;
    always_comb begin
        len      = mode_q == 2'd2 ? 8'(MULT_LEN) : mode_q == 2'd3 ? 8'(ADDSUB_LEN) : 8'(NTT_LEN);
        lat      = mode_q == 2'd2 ? 8'(MULT_LAT) : mode_q == 2'd3 ? 8'(ADDSUB_LAT) : 8'(NTT_LAT);
        last     = len + lat - 8'd1;
        last_stg = mode_q[1] ? 3'd0 : 3'(NUM_STAGES - 1);
        run      = state_q == RUN;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            mode_q  <= 2'd0;
            stage_q <= 3'd0;
            cnt_q   <= 8'd0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    mode_q  <= op;
                    stage_q <= 3'd0;
                    cnt_q   <= 8'd0;
                    state_q <= RUN;
                end
                RUN: begin
                    cnt_q <= cnt_q == last ? 8'd0 : cnt_q + 8'd1;
                    if (cnt_q == last && stage_q == last_stg) state_q <= FIN;
                    else if (cnt_q == last) stage_q <= stage_q + 3'd1;
                end
                default: begin
                    state_q <= IDLE;
                    stage_q <= 3'd0;
                end
            endcase
        end
    end
    assign mode       = mode_q;
    assign stage      = stage_q;
    assign cycle_cnt  = cnt_q;
    assign busy       = run;
    assign rd_en      = run && cnt_q < len;
    assign wr_en      = run && cnt_q >= lat && cnt_q <= last;
    assign stage_done = run && cnt_q == last;
    assign done       = state_q == FIN;
endmodule

// File: tb/tb_ntt_seq_ctrl.sv
// tb_ntt_seq_ctrl: directed table-driven checks of the sequencing controller
module tb_ntt_seq_ctrl;
    logic       clk, rst, start;
    logic [1:0] op, mode;
    logic [2:0] stage;
    logic [7:0] cycle_cnt;
    logic       rd_en, wr_en, busy, stage_done, done;
    int         cmp = 0;
    int         fails = 0;

    typedef struct {
        logic [1:0] op;
        int         len;
        int         lat;
        int         nst;
        int         total;
    } vec_t;
    vec_t vecs[4];

    ntt_seq_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .mode(mode), .stage(stage),
        .cycle_cnt(cycle_cnt), .rd_en(rd_en), .wr_en(wr_en), .busy(busy),
        .stage_done(stage_done), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [17:0] got();
        return {mode, stage, cycle_cnt, rd_en, wr_en, busy, stage_done, done};
    endfunction

    task automatic chk(input string name, input int t, input logic [17:0] g, input logic [17:0] e);
        cmp++;
        if (g !== e) begin
            fails++;
            $display("FAIL %s t=%0d got={mode,stage,cnt,rd,wr,busy,sd,done}=%h required=%h", name, t, g, e);
        end
    endtask

    task automatic run_op(input vec_t v, input int stop);
        logic [17:0] e;
        int per, c, s;
        per   = v.len + v.lat;
        start = 1'b1;
        op    = v.op;
        for (int t = 1; t <= v.total + 1 && t <= stop; t++) begin
            @(negedge clk);
            start = 1'b0;
            c = (t - 1) % per;
            s = (t - 1) / per;
            if (t < v.total)
                e = {v.op, 3'(s), 8'(c), 1'(c < v.len), 1'(c >= v.lat), 1'b1, 1'(c == per - 1), 1'b0};
            else if (t == v.total)
                e = {v.op, 3'(v.nst - 1), 8'd0, 5'b00001};
            else
                e = {v.op, 3'd0, 8'd0, 5'b00000};
            chk("run_op", t, got(), e);
        end
    endtask

    initial begin
        logic [17:0] e;
        int ph, c;
        logic b;
        vecs[0] = '{2'd0, 32, 6, 7, 267};
        vecs[1] = '{2'd1, 32, 6, 7, 267};
        vecs[2] = '{2'd2, 128, 12, 1, 141};
        vecs[3] = '{2'd3, 64, 4, 1, 69};
        rst = 1'b1; start = 1'b0; op = 2'd0;
        repeat (2) @(negedge clk);
        chk("reset", 0, got(), 18'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle", 0, got(), 18'd0);
        for (int i = 0; i < 4; i++) run_op(vecs[i], 1000);
        // NTT to stage 3 cnt 10, then stray start/op, then async reset
        run_op(vecs[0], 125);
        chk("mid_pos", 125, got(), {2'd0, 3'd3, 8'd10, 5'b11100});
        op = 2'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; op = 2'd0;
        chk("ignore_start", 126, got(), {2'd0, 3'd3, 8'd11, 5'b11100});
        #2 rst = 1'b1;
        #1 chk("async_rst", 0, got(), 18'd0);
        @(negedge clk);
        chk("rst_hold", 0, got(), 18'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_idle", 0, got(), 18'd0);
        run_op(vecs[2], 1000);
        // continuous start: 70-cycle ADDSUB period
        op = 2'd3; start = 1'b1;
        for (int t = 1; t <= 215; t++) begin
            @(negedge clk);
            ph = t % 70;
            b  = ph != 69 && ph != 0;
            c  = (ph >= 1 && ph <= 68) ? ph - 1 : 0;
            e  = {2'd3, 3'd0, 8'(c), 1'(b && c < 64), 1'(b && c >= 4), b, 1'(b && c == 67), 1'(ph == 69)};
            chk("b2b", t, got(), e);
        end
        start = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, fails);
        $finish;
    end
endmodule
